// File: rtl/regfile_port_ctrl_pkg.sv
// regfile_port_ctrl_pkg: shared widths, FSM state encoding and regfile strobe encoding
package regfile_port_ctrl_pkg;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NREG = 2 ** AW;
  typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} state_t;
  typedef enum logic [1:0] {RF_NOP = 2'b00, RF_WT = 2'b01, RF_RD = 2'b10, RF_RW = 2'b11} rf_strobe_t;
endpackage

// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if: fetch request, operand, result and regfile port bundle; master = controller, slave = its environment
interface regfile_port_ctrl_if;
  import regfile_port_ctrl_pkg::*;
  logic req_valid, req_ready, req_wb;
  logic [AW-1:0] req_src1, req_src2, req_dst;
  logic opnd_valid, opnd_ready, opnd_wb;
  logic [DW-1:0] opnd_a, opnd_b;
  logic [AW-1:0] opnd_dst;
  logic res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_dst;
  logic rf_en, rf_rd, rf_wt;
  logic [AW-1:0] rf_so1, rf_so2, rf_si;
  logic [DW-1:0] rf_ip, rf_op1, rf_op2;
  logic busy;
  modport master (
    input  req_valid, req_src1, req_src2, req_dst, req_wb, opnd_ready,
           res_valid, res_data, res_dst, rf_op1, rf_op2,
    output req_ready, opnd_valid, opnd_a, opnd_b, opnd_dst, opnd_wb, res_ready,
           rf_en, rf_rd, rf_wt, rf_so1, rf_so2, rf_si, rf_ip, busy
  );
  modport slave (
    output req_valid, req_src1, req_src2, req_dst, req_wb, opnd_ready,
           res_valid, res_data, res_dst, rf_op1, rf_op2,
    input  req_ready, opnd_valid, opnd_a, opnd_b, opnd_dst, opnd_wb, res_ready,
           rf_en, rf_rd, rf_wt, rf_so1, rf_so2, rf_si, rf_ip, busy
  );
endinterface

// File: rtl/regfile_port_ctrl_rf_scoreboard.sv
// rf_scoreboard: pending-write bit per register (set on fetch accept, clear on write commit) with src1/src2/dst hazard check
module rf_scoreboard
  import regfile_port_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] dst,
  input  logic          wb,
  output logic          hazard,
  output logic          any
);
  logic [NREG-1:0] pend;
  always_ff @(posedge clk)
    if (rst) pend <= '0;
    else pend <= (pend | (NREG'(set_en) << set_idx)) & ~(NREG'(clr_en) << clr_idx);
  assign hazard = pend[src1] | pend[src2] | (wb & pend[dst]);
  assign any = |pend;
endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: fetches operands from a registered 16x32 regfile, hands them to execute, writes results back, blocks stale reads
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  regfile_port_ctrl_if.master bus
);
  state_t state, state_n;
  rf_strobe_t strobe;
  logic [AW-1:0] so1, so2, si, dst_q, opnd_dst;
  logic [DW-1:0] ip, opnd_a, opnd_b;
  logic wb_q, opnd_wb, opnd_valid, hazard, any, accept, res_acc;
  rf_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .set_en(accept && bus.req_wb), .set_idx(bus.req_dst),
    .clr_en(strobe[0]), .clr_idx(si),
    .src1(bus.req_src1), .src2(bus.req_src2), .dst(bus.req_dst), .wb(bus.req_wb),
    .hazard(hazard), .any(any)
  );
  assign bus.req_ready = !rst && state == IDLE && !hazard;
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.res_ready = !rst;
  assign res_acc = bus.res_valid && !rst;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (accept ? READ : IDLE) :
              state == READ ? CAPT :
              state == CAPT ? HOLD :
              (opnd_valid && bus.opnd_ready) ? IDLE : HOLD;
  end
  // The read strobe is raised only on accept (IDLE), so it lasts exactly the READ cycle.
  always_ff @(posedge clk)
    if (rst) begin
      strobe <= RF_NOP;
      so1 <= '0;
      so2 <= '0;
      si <= '0;
      ip <= '0;
      dst_q <= '0;
      wb_q <= 1'b0;
      opnd_valid <= 1'b0;
      opnd_a <= '0;
      opnd_b <= '0;
      opnd_dst <= '0;
      opnd_wb <= 1'b0;
    end else begin
      strobe <= rf_strobe_t'({accept, res_acc});
      if (accept) begin
        so1 <= bus.req_src1;
        so2 <= bus.req_src2;
        dst_q <= bus.req_dst;
        wb_q <= bus.req_wb;
      end
      if (res_acc) begin
        si <= bus.res_dst;
        ip <= bus.res_data;
      end
      if (state == CAPT) begin
        opnd_valid <= 1'b1;
        opnd_a <= bus.rf_op1;
        opnd_b <= bus.rf_op2;
        opnd_dst <= dst_q;
        opnd_wb <= wb_q;
      end else if (opnd_valid && bus.opnd_ready) opnd_valid <= 1'b0;
    end
  assign bus.rf_en = 1'b1;
  assign {bus.rf_rd, bus.rf_wt} = strobe;
  assign bus.rf_so1 = so1;
  assign bus.rf_so2 = so2;
  assign bus.rf_si = si;
  assign bus.rf_ip = ip;
  assign bus.opnd_valid = opnd_valid;
  assign bus.opnd_a = opnd_a;
  assign bus.opnd_b = opnd_b;
  assign bus.opnd_dst = opnd_dst;
  assign bus.opnd_wb = opnd_wb;
  assign bus.busy = state != IDLE || any;
endmodule
